// File: rtl/div32_seq.sv
// -----------------------------------------------------------------------------
// div32_seq -- sequential 32-bit restoring divider (one quotient bit per clock)
//
// Purpose:
//   Divides a captured dividend by a captured divisor. Used for result scaling
//   and for checking factorial results by dividing them back down. Each step
//   uses a cla32 carry-lookahead adder as the trial subtractor (a + ~b + 1).
//   Results are loaded once per operation and then held stable until the
//   next accepted start.
//
// Optional feature:
//   DIV32_SIGNED_EN -- when defined, operands are two's complement. Magnitudes
//   are taken at capture time, the unsigned core runs unchanged, and the
//   signs are fixed up as the result is loaded (truncation toward zero).
//   When undefined, the divider is purely unsigned and has no sign logic.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   start        in   1   request pulse, sampled only while idle
//   dividend     in   32  numerator, captured on the accepted start edge
//   divisor      in   32  denominator, captured on the accepted start edge
//   busy         out  1   high while calculating and in the done state
//   done         out  1   one-cycle pulse; results valid from this cycle on
//   div_by_zero  out  1   set when the captured divisor was zero
//   quotient     out  32  result quotient
//   remainder    out  32  result remainder
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// cla32 -- 32-bit carry-lookahead adder
//   Eight 4-bit lookahead groups; each group's carries are derived only from
//   the group's carry-in and its generate/propagate terms, and the group
//   carries chain through the group generate/propagate terms.
//
// Ports:
//   a, b   in   32  addends
//   ci     in   1   carry in
//   s      out  32  sum
//   co     out  1   carry out
// -----------------------------------------------------------------------------
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    logic [31:0] gen_s;
    logic [31:0] prop_s;
    logic [32:0] carry_s;

    // Per-bit generate and propagate terms.
    assign gen_s  = a & b;
    assign prop_s = a ^ b;

    // Carry computation: 4-bit lookahead inside a group, group-level chaining.
    always_comb begin
        carry_s    = 33'd0;
        carry_s[0] = ci;
        for (int k = 0; k < 8; k++) begin
            carry_s[4*k+1] = gen_s[4*k]
                           | (prop_s[4*k] & carry_s[4*k]);
            carry_s[4*k+2] = gen_s[4*k+1]
                           | (prop_s[4*k+1] & gen_s[4*k])
                           | (prop_s[4*k+1] & prop_s[4*k] & carry_s[4*k]);
            carry_s[4*k+3] = gen_s[4*k+2]
                           | (prop_s[4*k+2] & gen_s[4*k+1])
                           | (prop_s[4*k+2] & prop_s[4*k+1] & gen_s[4*k])
                           | (prop_s[4*k+2] & prop_s[4*k+1] & prop_s[4*k]
                              & carry_s[4*k]);
            carry_s[4*k+4] = gen_s[4*k+3]
                           | (prop_s[4*k+3] & gen_s[4*k+2])
                           | (prop_s[4*k+3] & prop_s[4*k+2] & gen_s[4*k+1])
                           | (prop_s[4*k+3] & prop_s[4*k+2] & prop_s[4*k+1]
                              & gen_s[4*k])
                           | (prop_s[4*k+3] & prop_s[4*k+2] & prop_s[4*k+1]
                              & prop_s[4*k] & carry_s[4*k]);
        end
    end

    // Sum bits and final carry.
    assign s  = prop_s ^ carry_s[31:0];
    assign co = carry_s[32];

endmodule

// -----------------------------------------------------------------------------
// div32_seq -- top level
// -----------------------------------------------------------------------------
module div32_seq #(
    parameter int WIDTH = 32  // fixed: the cla32 trial subtractor is 32 bits
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0] LAST_STEP = 5'd31;

    // Two's complement negation, shared by operand magnitude and result fix-up.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    logic [1:0]  state_r;
    logic [4:0]  count_r;
    logic [31:0] q_r;          // dividend shifts out, quotient bits shift in
    logic [31:0] d_r;          // captured divisor (magnitude)
    logic [31:0] r_r;          // partial remainder
    logic        busy_r;
    logic        done_r;
    logic        dbz_r;
    logic [31:0] quotient_r;
    logic [31:0] remainder_r;

    logic [32:0] shift_s;      // {R, Q[31]}: 33 bits so a shifted-out MSB is kept
    logic [31:0] trial_s;
    logic        trial_co_s;
    logic        ok_s;
    logic [31:0] r_next_s;
    logic [31:0] q_next_s;
    logic [31:0] dividend_mag_s;
    logic [31:0] divisor_mag_s;
    logic [31:0] quot_load_s;
    logic [31:0] rem_load_s;

`ifdef DIV32_SIGNED_EN
    logic        neg_quot_r;   // operand signs differed
    logic        neg_rem_r;    // dividend was negative
`endif

    assign shift_s = {r_r, q_r[31]};

    // Trial subtraction S[31:0] - D; carry out of 1 means no borrow.
    cla32 u_sub (
        .a  (shift_s[31:0]),
        .b  (~d_r),
        .ci (1'b1),
        .s  (trial_s),
        .co (trial_co_s)
    );

    // If S[32] is set, S >= 2^32 > D, so the subtraction always fits and the
    // wrapped 32-bit difference is the exact remainder.
    assign ok_s     = trial_co_s | shift_s[32];
    assign q_next_s = {q_r[30:0], ok_s};

    // Restoring step: keep the difference only when the subtraction fits.
    always_comb begin
        r_next_s = shift_s[31:0];
        if (ok_s) begin
            r_next_s = trial_s;
        end else begin
            r_next_s = shift_s[31:0];
        end
    end

`ifdef DIV32_SIGNED_EN
    // Operand magnitudes at capture; 32'h80000000 maps to itself, which is
    // its correct unsigned magnitude.
    always_comb begin
        dividend_mag_s = dividend;
        divisor_mag_s  = divisor;
        if (dividend[31]) begin
            dividend_mag_s = neg32(dividend);
        end else begin
            dividend_mag_s = dividend;
        end
        if (divisor[31]) begin
            divisor_mag_s = neg32(divisor);
        end else begin
            divisor_mag_s = divisor;
        end
    end

    // Sign fix-up applied to the final step's results as they are loaded.
    always_comb begin
        quot_load_s = q_next_s;
        rem_load_s  = r_next_s;
        if (neg_quot_r) begin
            quot_load_s = neg32(q_next_s);
        end else begin
            quot_load_s = q_next_s;
        end
        if (neg_rem_r) begin
            rem_load_s = neg32(r_next_s);
        end else begin
            rem_load_s = r_next_s;
        end
    end
`else
    // Unsigned build: operands and results pass straight through.
    always_comb begin
        dividend_mag_s = dividend;
        divisor_mag_s  = divisor;
        quot_load_s    = q_next_s;
        rem_load_s     = r_next_s;
    end
`endif

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            count_r     <= 5'd0;
            q_r         <= 32'd0;
            d_r         <= 32'd0;
            r_r         <= 32'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
            quotient_r  <= 32'd0;
            remainder_r <= 32'd0;
`ifdef DIV32_SIGNED_EN
            neg_quot_r  <= 1'b0;
            neg_rem_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        q_r     <= dividend_mag_s;
                        d_r     <= divisor_mag_s;
                        r_r     <= 32'd0;
                        count_r <= 5'd0;
                        busy_r  <= 1'b1;
`ifdef DIV32_SIGNED_EN
                        neg_quot_r <= dividend[31] ^ divisor[31];
                        neg_rem_r  <= dividend[31];
`endif
                        if (divisor == 32'd0) begin
                            // Nothing to iterate: results are known now.
                            state_r     <= ST_DONE;
                            quotient_r  <= 32'hFFFF_FFFF;
                            remainder_r <= dividend;
                            dbz_r       <= 1'b1;
                        end else begin
                            state_r <= ST_CALC;
                            dbz_r   <= 1'b0;
                        end
                    end
                end
                ST_CALC: begin
                    done_r  <= 1'b0;
                    r_r     <= r_next_s;
                    q_r     <= q_next_s;
                    count_r <= count_r + 5'd1;
                    if (count_r == LAST_STEP) begin
                        state_r     <= ST_DONE;
                        quotient_r  <= quot_load_s;
                        remainder_r <= rem_load_s;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;

endmodule

// File: tb/tb_div32_seq.sv
// -----------------------------------------------------------------------------
// tb_div32_seq -- directed self-checking bench for div32_seq
// -----------------------------------------------------------------------------
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int          n_vec = 0;
    int          n_err = 0;
    int          lat;
    logic        busy_ok;
    logic        saw_done;

    div32_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called mid-cycle (#1 after a rising edge). Start is sampled at the next
    // edge (E0); lat is the number of edges after E0 until done is seen.
    // repulse_at > 0 raises start with other operands so it is sampled at
    // edge E<repulse_at>.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int repulse_at);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat      = 0;
        busy_ok  = busy;
        for (int i = 1; i <= 40; i++) begin
            if (i == repulse_at) begin
                start    = 1'b1;
                dividend = 32'd50;
                divisor  = 32'd5;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    // After run_op: done must drop on the following cycle.
    task automatic chk_pulse(input string tag);
        @(posedge clk); #1;
        chk(tag, {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
        chk("rst_quot", quotient, 32'd0);
        chk("rst_rem",  remainder, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 100 / 7
        run_op(32'd100, 32'd7, 0);
        chk("d100_lat",  lat, 32'd33);
        chk("d100_busy", {31'd0, busy_ok}, 32'd1);
        chk("d100_quot", quotient, 32'd14);
        chk("d100_rem",  remainder, 32'd2);
        chk("d100_dbz",  {31'd0, div_by_zero}, 32'd0);
        chk_pulse("d100_pulse");
        repeat (3) @(posedge clk); #1;
        chk("d100_hold", quotient, 32'd14);

`ifndef DIV32_SIGNED_EN
        // MSB-overflow path of the partial remainder
        run_op(32'hFFFF_FFFF, 32'h8000_0000, 0);
        chk("ovf_lat",  lat, 32'd33);
        chk("ovf_quot", quotient, 32'd1);
        chk("ovf_rem",  remainder, 32'h7FFF_FFFF);
        run_op(32'hFFFF_FFFF, 32'd1, 0);
        chk("one_quot", quotient, 32'hFFFF_FFFF);
        chk("one_rem",  remainder, 32'd0);
`endif

        // divide by zero then a normal op clears the flag
        run_op(32'd12345, 32'd0, 0);
        chk("dbz_lat",  lat, 32'd1);
        chk("dbz_flag", {31'd0, div_by_zero}, 32'd1);
        chk("dbz_quot", quotient, 32'hFFFF_FFFF);
        chk("dbz_rem",  remainder, 32'd12345);
        chk_pulse("dbz_pulse");
        run_op(32'd10, 32'd3, 0);
        chk("d10_flag", {31'd0, div_by_zero}, 32'd0);
        chk("d10_quot", quotient, 32'd3);
        chk("d10_rem",  remainder, 32'd1);

        // start while busy is ignored
        run_op(32'd1000, 32'd10, 10);
        chk("rep_lat",  lat, 32'd33);
        chk("rep_quot", quotient, 32'd100);
        chk("rep_rem",  remainder, 32'd0);
        @(posedge clk); #1;
        chk("rep_idle", {31'd0, busy}, 32'd0);

        // reset in the middle of an operation
        dividend = 32'h1234_5678;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk); #1;               // E0
        start = 1'b0;
        repeat (19) @(posedge clk);       // E1..E19
        #1;
        reset = 1'b1;                     // high through E20
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_done", {31'd0, done}, 32'd0);
        chk("mid_quot", quotient, 32'd0);
        chk("mid_rem",  remainder, 32'd0);
        @(posedge clk); #1;
        reset    = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk("mid_nodone", {31'd0, saw_done}, 32'd0);
        run_op(32'd200, 32'd9, 0);
        chk("post_lat",  lat, 32'd33);
        chk("post_quot", quotient, 32'd22);
        chk("post_rem",  remainder, 32'd2);

`ifdef DIV32_SIGNED_EN
        run_op(32'hFFFF_FFF9, 32'd2, 0);          // -7 / 2
        chk("s1_lat",  lat, 32'd33);
        chk("s1_quot", quotient, 32'hFFFF_FFFD);  // -3
        chk("s1_rem",  remainder, 32'hFFFF_FFFF); // -1
        run_op(32'd7, 32'hFFFF_FFFE, 0);          // 7 / -2
        chk("s2_quot", quotient, 32'hFFFF_FFFD);
        chk("s2_rem",  remainder, 32'd1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("s3_quot", quotient, 32'h8000_0000);
        chk("s3_rem",  remainder, 32'd0);
        chk("s3_flag", {31'd0, div_by_zero}, 32'd0);
`else
        // random operands: q*d + r == dividend and r < d
        for (int n = 0; n < 1000; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        inv_ok;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd1;
            if (n % 10 == 0) b = 32'd1;
            if (n % 10 == 1) a = 32'd0;
            if (n % 10 == 2) a = b >> 1;
            run_op(a, b, 0);
            inv_ok = (lat == 33) && (div_by_zero == 1'b0) && (remainder < b) &&
                     (({32'd0, quotient} * {32'd0, b} + {32'd0, remainder}) == {32'd0, a});
            chk($sformatf("rand%0d_%h_%h", n, a, b), {31'd0, inv_ok}, 32'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
